bcd_to_binary: RTL and testbench

- Clocked converter from a 4-digit packed BCD value (0..9999) to a 14-bit unsigned binary value.
- Uses an iterative reverse double-dabble: shift right, then subtract 3 from any BCD digit that is 8 or more.
- Start/valid handshake; sits between the calculator's decimal keypad/display path and the binary ALU.

---
 rtl/bcd_pkg.sv | 41 ++++
 rtl/bcd_digit_adj.sv | 11 +
 rtl/bcd_to_binary.sv | 142 ++++++++++++++
 tb/tb_bcd_to_binary.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helpers for the bcd_to_binary converter.
package bcd_pkg;

    localparam int unsigned NDIG   = 4;
    localparam int unsigned BIN_W  = 14;
    localparam int unsigned BCD_W  = 4 * NDIG;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_SUB    = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_e;

    function automatic logic bcd_has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > DIGIT_MAX) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Horner evaluation with x*10 = (x << 3) + (x << 1), so no multiplier is built.
    function automatic logic [BIN_W-1:0] bcd_weighted_sum(input logic [BCD_W-1:0] v);
        logic [BIN_W-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            acc = (acc << 3) + (acc << 1) + BIN_W'(v[4*(NDIG-1-i) +: 4]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One reverse double-dabble correction: a digit nibble of 8 or more gets 3 subtracted.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= ADJ_THRESH) ? (din - ADJ_SUB) : din;

endmodule

// File: rtl/bcd_to_binary.sv
// Packed BCD to binary converter with start/valid handshake (reverse double-dabble).
// Define BCD2BIN_FAST_EN for the single-pass shift-add build with no CONV state.
module bcd_to_binary
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BCD_W-1:0] bcd,
    output logic             busy,
    output logic [BIN_W-1:0] bin,
    output logic             valid,
    output logic             err
);

    logic [BIN_W-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             bad_in;

    assign bad_in = bcd_has_bad_digit(bcd);

`ifdef BCD2BIN_FAST_EN

    logic             pend_q;
    logic             tag_q;
    logic [BIN_W-1:0] res_q;

    // Capture stage: result and error tag are formed at the capture edge, published one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            tag_q  <= 1'b0;
            res_q  <= '0;
        end else begin
            pend_q <= start;
            if (start) begin
                tag_q <= bad_in;
                res_q <= bad_in ? '0 : bcd_weighted_sum(bcd);
            end
        end
    end

    always_comb begin
        bin_d   = bin_q;
        err_d   = err_q;
        valid_d = pend_q;
        if (pend_q) begin
            bin_d = res_q;
            err_d = tag_q;
        end
    end

    assign busy = 1'b0;

`else

    state_e            state_q, state_d;
    logic [WORK_W-1:0] work_q, work_d;
    logic [WORK_W-1:0] shifted, stepped;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tag_q, tag_d;

    assign shifted                 = work_q >> 1;
    assign stepped[BIN_W-1:0]      = shifted[BIN_W-1:0];

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (shifted[BIN_W + 4*gi +: 4]),
            .dout (stepped[BIN_W + 4*gi +: 4])
        );
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        bin_d   = bin_q;
        err_d   = err_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = {bcd, {BIN_W{1'b0}}};
                    tag_d   = bad_in;
                    cnt_d   = '0;
                    state_d = bad_in ? DONE : CONV;
                end
            end
            CONV: begin
                work_d = stepped;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bin_d   = tag_q ? '0 : work_q[BIN_W-1:0];
                err_d   = tag_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            tag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

    assign busy = (state_q != IDLE);

`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bin   = bin_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary; expectations queued at start, compared at valid.
// Honours BCD2BIN_FAST_EN for the expected latency and busy behaviour.
module tb_bcd_to_binary;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] bcd;
    logic        busy;
    logic [13:0] bin;
    logic        valid;
    logic        err;

`ifdef BCD2BIN_FAST_EN
    localparam int   LAT_OK   = 1;
    localparam int   LAT_BAD  = 1;
    localparam logic BUSY_EXP = 1'b0;
`else
    localparam int   LAT_OK   = 15;
    localparam int   LAT_BAD  = 1;
    localparam logic BUSY_EXP = 1'b1;
`endif

    typedef struct {
        logic [13:0] bin;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    bcd_to_binary dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .bin   (bin),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [15:0] v, output logic [13:0] b, output logic e);
        int acc;
        int d;
        acc = 0;
        e   = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) e = 1'b1;
            acc = acc * 10 + d;
        end
        b = e ? 14'd0 : 14'(acc);
    endfunction

    // Drive a one-cycle start; returns #1 after the capture edge.
    task automatic pulse_start(input logic [15:0] v);
        exp_t x;
        model(v, x.bin, x.err);
        x.lat = x.err ? LAT_BAD : LAT_OK;
        sb.push_back(x);
        bcd   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcd   = 16'hFFFF;
    endtask

    task automatic wait_valid(output int edges, output bit tmo);
        edges = 0;
        tmo   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (valid === 1'b1) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
        checks++; if (bin !== 14'd0) begin failures++; $display("FAIL reset_bin got=%0d want=0", bin); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b want=0", valid); end
    endtask

    task automatic test_single();
        logic [15:0] vals [3] = '{16'h0001, 16'h0123, 16'h0999};
        exp_t        x;
        int          edges;
        bit          tmo;
        foreach (vals[i]) begin
            pulse_start(vals[i]);
            checks++; if (busy !== BUSY_EXP) begin failures++; $display("FAIL single_busy v=%h got=%b want=%b", vals[i], busy, BUSY_EXP); end
            wait_valid(edges, tmo);
            x = sb.pop_front();
            checks++; if (tmo || edges != x.lat) begin failures++; $display("FAIL single_latency v=%h got=%0d tmo=%0b want=%0d", vals[i], edges, tmo, x.lat); end
            checks++; if (bin !== x.bin) begin failures++; $display("FAIL single_bin v=%h got=%0d want=%0d", vals[i], bin, x.bin); end
            checks++; if (err !== x.err) begin failures++; $display("FAIL single_err v=%h got=%b want=%b", vals[i], err, x.err); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_at_valid v=%h got=%b want=0", vals[i], busy); end
            @(posedge clk);
            #1;
            checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_valid_width v=%h got=%b want=0", vals[i], valid); end
        end
    endtask

    // Each next start is driven in the cycle its predecessor's valid is high.
    task automatic test_back_to_back();
        logic [15:0] vals [3] = '{16'h1449, 16'h2531, 16'h9999};
        exp_t        x;
        int          edges;
        bit          tmo;
        pulse_start(vals[0]);
        for (int i = 0; i < 3; i++) begin
            wait_valid(edges, tmo);
            x = sb.pop_front();
            checks++; if (tmo || edges != x.lat) begin failures++; $display("FAIL b2b_latency v=%h got=%0d tmo=%0b want=%0d", vals[i], edges, tmo, x.lat); end
            checks++; if (bin !== x.bin) begin failures++; $display("FAIL b2b_bin v=%h got=%0d want=%0d", vals[i], bin, x.bin); end
            checks++; if (err !== x.err) begin failures++; $display("FAIL b2b_err v=%h got=%b want=%b", vals[i], err, x.err); end
            if (i < 2) begin
                pulse_start(vals[i+1]);
            end else begin
                @(posedge clk);
                #1;
            end
            checks++; if (valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_width v=%h got=%b want=0", vals[i], valid); end
        end
    endtask

    task automatic test_zero();
        exp_t x;
        int   edges;
        bit   tmo;
        pulse_start(16'h0000);
        wait_valid(edges, tmo);
        x = sb.pop_front();
        checks++; if (tmo || edges != x.lat) begin failures++; $display("FAIL zero_latency got=%0d tmo=%0b want=%0d", edges, tmo, x.lat); end
        checks++; if (bin !== x.bin) begin failures++; $display("FAIL zero_bin got=%0d want=%0d", bin, x.bin); end
        checks++; if (err !== x.err) begin failures++; $display("FAIL zero_err got=%b want=%b", err, x.err); end
    endtask

    task automatic test_error();
        logic [15:0] vals [2] = '{16'h00A5, 16'h0042};
        exp_t        x;
        int          edges;
        bit          tmo;
        foreach (vals[i]) begin
            pulse_start(vals[i]);
            wait_valid(edges, tmo);
            x = sb.pop_front();
            checks++; if (tmo || edges != x.lat) begin failures++; $display("FAIL error_latency v=%h got=%0d tmo=%0b want=%0d", vals[i], edges, tmo, x.lat); end
            checks++; if (bin !== x.bin) begin failures++; $display("FAIL error_bin v=%h got=%0d want=%0d", vals[i], bin, x.bin); end
            checks++; if (err !== x.err) begin failures++; $display("FAIL error_err v=%h got=%b want=%b", vals[i], err, x.err); end
        end
    endtask

    task automatic test_busy_ignore();
        exp_t        x;
        int          nvalid = 0;
        int          vedge  = 0;
        logic [13:0] vbin   = '0;
        pulse_start(16'h0123);
        for (int i = 1; i <= 25; i++) begin
            if (i == 3 || i == 7) begin
                start = 1'b1;
                bcd   = 16'h0456;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i == 5) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy got=%b want=1", busy); end
            end
            if (valid === 1'b1) begin
                nvalid++;
                if (vedge == 0) begin
                    vedge = i;
                    vbin  = bin;
                end
            end
        end
        x = sb.pop_front();
        checks++; if (nvalid != 1) begin failures++; $display("FAIL ignore_count got=%0d want=1", nvalid); end
        checks++; if (vedge != x.lat) begin failures++; $display("FAIL ignore_latency got=%0d want=%0d", vedge, x.lat); end
        checks++; if (vbin !== x.bin) begin failures++; $display("FAIL ignore_bin got=%0d want=%0d", vbin, x.bin); end
    endtask

    task automatic test_reset_abort();
        exp_t x;
        int   edges;
        bit   tmo;
        int   nv = 0;
        pulse_start(16'h0555);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b want=0", valid); end
        checks++; if (bin !== 14'd0) begin failures++; $display("FAIL abort_bin got=%0d want=0", bin); end
        sb.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) nv++;
        end
        checks++; if (nv != 0) begin failures++; $display("FAIL abort_no_valid got=%0d want=0", nv); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pulse_start(16'h0777);
        wait_valid(edges, tmo);
        x = sb.pop_front();
        checks++; if (tmo || edges != x.lat) begin failures++; $display("FAIL abort_latency got=%0d tmo=%0b want=%0d", edges, tmo, x.lat); end
        checks++; if (bin !== x.bin) begin failures++; $display("FAIL abort_bin_after got=%0d want=%0d", bin, x.bin); end
        checks++; if (err !== x.err) begin failures++; $display("FAIL abort_err_after got=%b want=%b", err, x.err); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bcd   = 16'h0000;
        test_reset();
        test_single();
        test_back_to_back();
        test_zero();
        test_error();
`ifndef BCD2BIN_FAST_EN
        test_busy_ignore();
`endif
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
